// File: rtl/combo_tracker.sv
// combo_tracker: edge-detected hit/miss events to saturating combo, best record, multiplier tier and status pulses
module combo_tracker #(
  parameter int WIDTH = 7,
  parameter int NFC_INC = 1,
  parameter int FC_INC = 2,
  parameter int TIER_STEP = 5,
  parameter int NUM_TIERS = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int MULT_W = $clog2(NUM_TIERS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic              non_full_clear_hit,
  input  logic              full_clear_hit,
  output logic [WIDTH-1:0]  combo_val,
  output logic [WIDTH-1:0]  best_combo,
  output logic [MULT_W-1:0] multiplier,
  output logic              tier_up,
  output logic              combo_broken
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic miss_d, nfc_d, fc_d;
  logic miss_e, nfc_e, fc_e, hit, timeout;
  logic [TW-1:0] timer, timer_n;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] combo_n, best_n, tier;
  logic [MULT_W-1:0] mult_n;
  always_comb begin
    miss_e = miss & ~miss_d;
    nfc_e = non_full_clear_hit & ~nfc_d;
    fc_e = full_clear_hit & ~fc_d;
    hit = fc_e | nfc_e;
    // extra carry bit catches overflow so the count saturates instead of wrapping
    sum = {1'b0, combo_val} + (fc_e ? (WIDTH+1)'(FC_INC) : nfc_e ? (WIDTH+1)'(NFC_INC) : '0);
    timeout = TIMEOUT_CYCLES > 0 && state == ACTIVE && !miss_e && !hit && timer == T_LAST;
    combo_n = miss_e || timeout ? '0 : hit ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) : combo_val;
    best_n = combo_n > best_combo ? combo_n : best_combo;
    tier = combo_n / WIDTH'(TIER_STEP);
    mult_n = tier >= WIDTH'(NUM_TIERS - 1) ? MULT_W'(NUM_TIERS) : MULT_W'(tier) + MULT_W'(1);
    state_n = state == IDLE ? (hit && !miss_e ? ACTIVE : IDLE) : (miss_e || timeout ? IDLE : ACTIVE);
    timer_n = state == ACTIVE && state_n == ACTIVE && !hit ? timer + TW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_d <= 1'b0;
      nfc_d <= 1'b0;
      fc_d <= 1'b0;
      combo_val <= '0;
      best_combo <= '0;
      multiplier <= MULT_W'(1);
      tier_up <= 1'b0;
      combo_broken <= 1'b0;
      timer <= '0;
      state <= IDLE;
    end else begin
      miss_d <= miss;
      nfc_d <= non_full_clear_hit;
      fc_d <= full_clear_hit;
      combo_val <= combo_n;
      best_combo <= best_n;
      multiplier <= mult_n;
      tier_up <= mult_n > multiplier;
      combo_broken <= (miss_e && state == ACTIVE) || timeout;
      timer <= timer_n;
      state <= state_n;
    end
  end
endmodule
